axi_slave_mem_bridge: RTL and testbench
=======================================

// Module: axi_slave_mem_bridge
// PURPOSE
//  AXI4 slave (responder) that turns AXI read/write bursts from the interconnect into accesses on a word-wide memory port.
//  Drives a BRAM-style memory with 1-cycle read latency. Serves one transaction at a time. ID is appended/stripped by the interconnect.
// PARAMETERS
//  DATA_WIDTH       32   AXI and memory data width; WSTRB/mem_we are DATA_WIDTH/8 bits
//  ADDR_WIDTH       32   AXI byte-address width
//  MEM_ADDR_WIDTH   12   memory word-address width (2^12 words = 16 KiB)
// PORTS
//  clk              in   1                clock; all logic on rising edge
//  rst              in   1                asynchronous reset, active-high
//  S_AXI_AWADDR     in   ADDR_WIDTH       write burst start byte address
//  S_AXI_AWLEN      in   8                write beats - 1
//  S_AXI_AWVALID    in   1                write address valid
//  S_AXI_AWREADY    out  1                write address accepted
//  S_AXI_WDATA      in   DATA_WIDTH       write data
//  S_AXI_WSTRB      in   DATA_WIDTH/8     byte enables
//  S_AXI_WVALID     in   1                write data valid
//  S_AXI_WREADY     out  1                write data accepted
//  S_AXI_BRESP      out  2                write response (OKAY=00, SLVERR=10)
//  S_AXI_BVALID     out  1                write response valid
//  S_AXI_BREADY     in   1                write response taken
//  S_AXI_ARADDR     in   ADDR_WIDTH       read burst start byte address
//  S_AXI_ARLEN      in   8                read beats - 1
//  S_AXI_ARVALID    in   1                read address valid
//  S_AXI_ARREADY    out  1                read address accepted
//  S_AXI_RDATA      out  DATA_WIDTH       read data
//  S_AXI_RRESP      out  2                read response
//  S_AXI_RLAST      out  1                last read beat
//  S_AXI_RVALID     out  1                read data valid
//  S_AXI_RREADY     in   1                read data taken
//  mem_en           out  1                memory access strobe
//  mem_we           out  DATA_WIDTH/8     per-byte write enable (all 0 = read)
//  mem_addr         out  MEM_ADDR_WIDTH   memory word address
//  mem_wdata        out  DATA_WIDTH       memory write data
//  mem_rdata        in   DATA_WIDTH       read data, valid cycle after mem_en; held while mem_en=0
// BEHAVIOUR
//  - Reset (async, any state, aborts in-flight burst with no response): state IDLE, all READY/VALID/mem_en/mem_we=0, BRESP=RRESP=00, RLAST=0, rr bit=0.
//  - FSM: IDLE, WR_DATA, WR_RESP, RD_ISSUE, RD_RESP. AWREADY/ARREADY are 1 only in IDLE for the granted channel. Accept: latch word addr=ADDR[MEM_ADDR_WIDTH+1:2], len, beat cnt=0.
//  - Arbitration in IDLE: one VALID wins. Both VALID: rr bit picks (0=read, 1=write). rr toggles to the other channel after each grant.
//  - Write: AW accept cycle 0 -> WR_DATA, WREADY=1 from cycle 1. Per W handshake in that cycle: mem_en=1, mem_we=WSTRB, mem_wdata=WDATA, mem_addr=addr; addr+1, cnt+1. Beat len+1 -> WR_RESP.
//  - WR_RESP: BVALID=1, held with BRESP stable until BREADY -> IDLE. WLAST is not used; the beat count alone ends the burst.
//  - Read: AR accept cycle 0 -> RD_ISSUE cycle 1 (mem_en=1, mem_we=0) -> RD_RESP cycle 2: RVALID=1, RDATA=mem_rdata, RLAST=(cnt==len).
//  - RD_RESP: RDATA/RRESP/RLAST stay stable until RREADY. On handshake: last beat -> IDLE, else addr+1, cnt+1 -> RD_ISSUE. Throughput is 1 beat per 2 cycles.
//  - Word address wraps modulo 2^MEM_ADDR_WIDTH. AWLEN/ARLEN=0 is a single beat, 255 gives 256 beats. Byte-offset address bits [1:0] are ignored.
// CONFIGURATION
//  AXI_SLV_ERRCHK_EN defined: ADDR bits above MEM_ADDR_WIDTH+1 nonzero at accept -> error burst: mem_en never asserted, every R beat RDATA=0/RRESP=10, BRESP=10; handshakes/timing unchanged.
//  Undefined: upper address bits ignored (aliasing), BRESP/RRESP always 00.
// STRUCTURE
//  Package axi_mem_pkg: RESP_OKAY/RESP_SLVERR localparams, state enum typedef.
//  Single module, no sub-module (arbiter is one rr flop).
// TESTING
//  AW addr 0x10 len 0, W 0xDEADBEEF strb 0xF, BREADY=1 -> mem_we=0xF addr 4 once, BVALID cycle after W, BRESP=00.
//  AR addr 0x10 len 3 with mem model, RREADY toggling 1/0 -> 4 beats from addrs 4..7 in order, RDATA stable while stalled, RLAST only on beat 4.
//  AWVALID and ARVALID both high in same cycle, twice in a row -> read granted first, then write; neither lost.
//  AW addr 0x3FFC len 1 (MEM_ADDR_WIDTH=12) -> beat writes to addr 0xFFF then 0x000.
//  rst pulsed mid 8-beat read after beat 3 -> all outputs 0 next edge, IDLE, new AR served normally.
//  ERRCHK_EN: AR addr 0x0001_0000 len 1 -> 2 beats RRESP=10 RDATA=0, mem_en stays 0; undefined: reads alias word 0.

Source files
------------

// File: rtl/axi_mem_pkg.sv
// Shared response codes and FSM state encoding for the AXI slave memory bridge.
package axi_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_WR_RESP,
        ST_RD_ISSUE,
        ST_RD_RESP
    } state_t;

endpackage

// File: rtl/axi_slave_mem_bridge.sv
// AXI4 slave serving one burst at a time onto a 1-cycle-latency BRAM port.
// Optional macro AXI_SLV_ERRCHK_EN: out-of-range upper address bits yield SLVERR bursts.
module axi_slave_mem_bridge
    import axi_mem_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [7:0]                S_AXI_AWLEN,
    input  logic                      S_AXI_AWVALID,
    output logic                      S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                      S_AXI_WVALID,
    output logic                      S_AXI_WREADY,
    output logic [1:0]                S_AXI_BRESP,
    output logic                      S_AXI_BVALID,
    input  logic                      S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [7:0]                S_AXI_ARLEN,
    input  logic                      S_AXI_ARVALID,
    output logic                      S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                S_AXI_RRESP,
    output logic                      S_AXI_RLAST,
    output logic                      S_AXI_RVALID,
    input  logic                      S_AXI_RREADY,
    output logic                      mem_en,
    output logic [DATA_WIDTH/8-1:0]   mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);

`ifdef AXI_SLV_ERRCHK_EN
    localparam logic ERRCHK = 1'b1;
`else
    localparam logic ERRCHK = 1'b0;
`endif

    localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_ONE = 1;

    state_t                    state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]                len_q, len_d;
    logic [7:0]                cnt_q, cnt_d;
    logic                      err_q, err_d;
    logic                      rr_q, rr_d;

    logic aw_hi, ar_hi, grant_rd, grant_wr, last_beat;
    logic unused_addr_lsbs;

    assign aw_hi            = |S_AXI_AWADDR[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2];
    assign ar_hi            = |S_AXI_ARADDR[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2];
    assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // rr_q=0 favours read on a tie, rr_q=1 favours write
    assign grant_rd  = S_AXI_ARVALID && (!S_AXI_AWVALID || !rr_q);
    assign grant_wr  = S_AXI_AWVALID && (!S_AXI_ARVALID || rr_q);
    assign last_beat = (cnt_q == len_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        rr_d          = rr_q;
        S_AXI_AWREADY = 1'b0;
        S_AXI_ARREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        S_AXI_BRESP   = RESP_OKAY;
        S_AXI_RVALID  = 1'b0;
        S_AXI_RDATA   = '0;
        S_AXI_RRESP   = RESP_OKAY;
        S_AXI_RLAST   = 1'b0;
        mem_en        = 1'b0;
        mem_we        = '0;
        mem_addr      = addr_q;
        mem_wdata     = S_AXI_WDATA;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_rd) begin
                    S_AXI_ARREADY = 1'b1;
                    addr_d        = S_AXI_ARADDR[MEM_ADDR_WIDTH+1:2];
                    len_d         = S_AXI_ARLEN;
                    cnt_d         = '0;
                    err_d         = ERRCHK & ar_hi;
                    rr_d          = 1'b1;
                    state_d       = ST_RD_ISSUE;
                end else if (grant_wr) begin
                    S_AXI_AWREADY = 1'b1;
                    addr_d        = S_AXI_AWADDR[MEM_ADDR_WIDTH+1:2];
                    len_d         = S_AXI_AWLEN;
                    cnt_d         = '0;
                    err_d         = ERRCHK & aw_hi;
                    rr_d          = 1'b0;
                    state_d       = ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                S_AXI_WREADY = 1'b1;
                if (S_AXI_WVALID) begin
                    mem_en = !err_q;
                    mem_we = err_q ? '0 : S_AXI_WSTRB;
                    addr_d = addr_q + ADDR_ONE;
                    cnt_d  = cnt_q + 8'd1;
                    if (last_beat) state_d = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                S_AXI_BVALID = 1'b1;
                S_AXI_BRESP  = err_q ? RESP_SLVERR : RESP_OKAY;
                if (S_AXI_BREADY) state_d = ST_IDLE;
            end
            ST_RD_ISSUE: begin
                mem_en  = !err_q;
                state_d = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                // mem_rdata is held by the memory while mem_en is low, so RDATA stays stable
                S_AXI_RVALID = 1'b1;
                S_AXI_RDATA  = err_q ? '0 : mem_rdata;
                S_AXI_RRESP  = err_q ? RESP_SLVERR : RESP_OKAY;
                S_AXI_RLAST  = last_beat;
                if (S_AXI_RREADY) begin
                    if (last_beat) begin
                        state_d = ST_IDLE;
                    end else begin
                        addr_d  = addr_q + ADDR_ONE;
                        cnt_d   = cnt_q + 8'd1;
                        state_d = ST_RD_ISSUE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_slave_mem_bridge.sv
// Randomised self-checking bench for axi_slave_mem_bridge with a transaction-level reference model.
module tb_axi_slave_mem_bridge;

    localparam int TMO = 3000;
`ifdef AXI_SLV_ERRCHK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] S_AXI_AWADDR = '0;
    logic [7:0]  S_AXI_AWLEN = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [31:0] S_AXI_ARADDR = '0;
    logic [7:0]  S_AXI_ARLEN = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RLAST;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    always #5 clk = ~clk;

    axi_slave_mem_bridge dut (
        .clk(clk), .rst(rst),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RLAST(S_AXI_RLAST),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] fill(input int i);
        return (i * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // BRAM environment: read-first, 1-cycle latency, output held while idle
    logic [31:0] tb_mem [4096];
    logic        mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 4096; i++) tb_mem[i] <= fill(i);
            mem_loaded <= 1'b1;
        end else if (mem_en) begin
            mem_rdata <= tb_mem[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) tb_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    // Reference model: shadow memory plus expected-event queues
    typedef struct { logic [11:0] addr; logic [3:0] we; logic [31:0] data; } mop_t;
    typedef struct { logic [31:0] data; logic [1:0] resp; logic last; } rbeat_t;
    logic [31:0] ref_mem [4096];
    mop_t        exp_mem[$];
    rbeat_t      exp_r[$];
    logic [1:0]  exp_b[$];
    logic [31:0] wr_data [256];
    logic [3:0]  wr_strb [256];
    logic [31:0] rd_cap  [256];
    int checks = 0;
    int errors = 0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_err(input logic [31:0] addr);
        return ERR_EN && (addr[31:14] != 0);
    endfunction

    task automatic expect_write(input logic [31:0] addr, input int len);
        logic [11:0] w;
        bit e;
        e = is_err(addr);
        for (int i = 0; i <= len; i++) begin
            w = addr[13:2] + 12'(i);
            if (!e) begin
                exp_mem.push_back('{w, wr_strb[i], wr_data[i]});
                for (int b = 0; b < 4; b++)
                    if (wr_strb[i][b]) ref_mem[w][8*b +: 8] = wr_data[i][8*b +: 8];
            end
        end
        exp_b.push_back(e ? 2'b10 : 2'b00);
    endtask

    task automatic expect_read(input logic [31:0] addr, input int len, input int nbeats);
        logic [11:0] w;
        bit e;
        e = is_err(addr);
        for (int i = 0; i < nbeats; i++) begin
            w = addr[13:2] + 12'(i);
            if (!e) exp_mem.push_back('{w, 4'h0, 32'h0});
            exp_r.push_back('{e ? 32'h0 : ref_mem[w], e ? 2'b10 : 2'b00, i == len});
        end
    endtask

    // Compare process
    logic        r_stall_q = 1'b0, b_stall_q = 1'b0;
    logic [31:0] r_data_q = '0;
    logic [1:0]  r_resp_q = '0, b_resp_q = '0;
    logic        r_last_q = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_en) begin
                if (exp_mem.size() == 0) check(0, "mem_unexpected", {20'h0, mem_addr}, 32'h0);
                else begin
                    mop_t m;
                    m = exp_mem.pop_front();
                    check(mem_addr == m.addr, "mem_addr", {20'h0, mem_addr}, {20'h0, m.addr});
                    check(mem_we == m.we, "mem_we", {28'h0, mem_we}, {28'h0, m.we});
                    if (m.we != 0) check(mem_wdata == m.data, "mem_wdata", mem_wdata, m.data);
                end
            end
            if (S_AXI_RVALID && S_AXI_RREADY) begin
                if (exp_r.size() == 0) check(0, "r_unexpected", S_AXI_RDATA, 32'h0);
                else begin
                    rbeat_t r;
                    r = exp_r.pop_front();
                    check(S_AXI_RDATA == r.data, "rdata", S_AXI_RDATA, r.data);
                    check({S_AXI_RRESP, S_AXI_RLAST} == {r.resp, r.last}, "rresp_rlast",
                          {29'h0, S_AXI_RRESP, S_AXI_RLAST}, {29'h0, r.resp, r.last});
                end
            end
            if (S_AXI_BVALID && S_AXI_BREADY) begin
                if (exp_b.size() == 0) check(0, "b_unexpected", {30'h0, S_AXI_BRESP}, 32'h0);
                else begin
                    logic [1:0] eb;
                    eb = exp_b.pop_front();
                    check(S_AXI_BRESP == eb, "bresp", {30'h0, S_AXI_BRESP}, {30'h0, eb});
                end
            end
            if (r_stall_q)
                check(S_AXI_RVALID && S_AXI_RDATA == r_data_q && S_AXI_RRESP == r_resp_q
                      && S_AXI_RLAST == r_last_q, "r_stable", S_AXI_RDATA, r_data_q);
            if (b_stall_q)
                check(S_AXI_BVALID && S_AXI_BRESP == b_resp_q, "b_stable",
                      {30'h0, S_AXI_BRESP}, {30'h0, b_resp_q});
            r_stall_q <= S_AXI_RVALID && !S_AXI_RREADY;
            b_stall_q <= S_AXI_BVALID && !S_AXI_BREADY;
            r_data_q  <= S_AXI_RDATA;
            r_resp_q  <= S_AXI_RRESP;
            r_last_q  <= S_AXI_RLAST;
            b_resp_q  <= S_AXI_BRESP;
        end else begin
            r_stall_q <= 1'b0;
            b_stall_q <= 1'b0;
        end
    end

    // Drivers: inputs change #1 after posedge, handshakes observed at negedge
    task automatic drive_write(input logic [31:0] addr, input int len);
        int n = 0;
        bit done = 0;
        S_AXI_AWADDR = addr; S_AXI_AWLEN = 8'(len); S_AXI_AWVALID = 1'b1;
        do begin @(negedge clk); n++; end while (!S_AXI_AWREADY && n < TMO);
        if (!S_AXI_AWREADY) check(0, "aw_timeout", 32'(n), 32'(TMO));
        @(posedge clk); #1 S_AXI_AWVALID = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            S_AXI_WDATA = wr_data[i]; S_AXI_WSTRB = wr_strb[i]; S_AXI_WVALID = 1'b1;
            n = 0;
            do begin @(negedge clk); n++; end while (!S_AXI_WREADY && n < TMO);
            if (!S_AXI_WREADY) check(0, "w_timeout", 32'(n), 32'(TMO));
            @(posedge clk); #1 S_AXI_WVALID = 1'b0;
        end
        n = 0;
        while (!done && n < TMO) begin
            S_AXI_BREADY = ($urandom_range(0, 2) != 0);
            @(negedge clk); n++;
            done = S_AXI_BVALID && S_AXI_BREADY;
            @(posedge clk); #1;
        end
        S_AXI_BREADY = 1'b0;
        if (!done) check(0, "b_timeout", 32'(n), 32'(TMO));
    endtask

    task automatic drive_read(input logic [31:0] addr, input int len, input bit toggle, input int abort_after);
        int n = 0, beats = 0;
        bit done = 0, tog = 1;
        S_AXI_ARADDR = addr; S_AXI_ARLEN = 8'(len); S_AXI_ARVALID = 1'b1;
        do begin @(negedge clk); n++; end while (!S_AXI_ARREADY && n < TMO);
        if (!S_AXI_ARREADY) check(0, "ar_timeout", 32'(n), 32'(TMO));
        @(posedge clk); #1 S_AXI_ARVALID = 1'b0;
        n = 0;
        while (!done && n < TMO) begin
            S_AXI_RREADY = toggle ? tog : ($urandom_range(0, 3) != 0);
            tog = !tog;
            @(negedge clk); n++;
            if (S_AXI_RVALID && S_AXI_RREADY) begin
                rd_cap[beats] = S_AXI_RDATA;
                beats++;
                if (S_AXI_RLAST || beats == abort_after) done = 1;
            end
            @(posedge clk); #1;
        end
        S_AXI_RREADY = 1'b0;
        if (!done) check(0, "r_timeout", 32'(beats), 32'(len + 1));
    endtask

    task automatic fill_wr(input int len, input bit full_strb);
        for (int i = 0; i <= len; i++) begin
            wr_data[i] = $urandom;
            wr_strb[i] = full_strb ? 4'hF : 4'($urandom_range(0, 15));
        end
    endtask

    task automatic check_drained(input string name);
        check(exp_mem.size() == 0 && exp_r.size() == 0 && exp_b.size() == 0, name,
              32'(exp_mem.size() + exp_r.size() + exp_b.size()), 32'h0);
    endtask

    initial begin
        logic [31:0] a, wrap_d1;
        int len;
        for (int i = 0; i < 4096; i++) ref_mem[i] = fill(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check({S_AXI_AWREADY, S_AXI_ARREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_RVALID,
               S_AXI_RLAST, mem_en, mem_we, S_AXI_BRESP, S_AXI_RRESP} == '0, "reset_outputs",
              {20'h0, S_AXI_AWREADY, S_AXI_ARREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_RVALID,
               S_AXI_RLAST, mem_en, mem_we, S_AXI_BRESP}, 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        // Single-beat write with BREADY held high
        wr_data[0] = 32'hDEADBEEF; wr_strb[0] = 4'hF;
        expect_write(32'h10, 0);
        S_AXI_AWADDR = 32'h10; S_AXI_AWLEN = 8'd0; S_AXI_AWVALID = 1'b1; S_AXI_BREADY = 1'b1;
        @(negedge clk); check(S_AXI_AWREADY, "t1_awready", {31'h0, S_AXI_AWREADY}, 32'h1);
        @(posedge clk); #1 S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = 32'hDEADBEEF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        @(negedge clk);
        check(mem_en && mem_we == 4'hF && mem_addr == 12'd4, "t1_mem_write",
              {15'h0, mem_en, mem_we, mem_addr}, {15'h0, 1'b1, 4'hF, 12'd4});
        @(posedge clk); #1 S_AXI_WVALID = 1'b0;
        @(negedge clk);
        check(S_AXI_BVALID && S_AXI_BRESP == 2'b00, "t1_bvalid",
              {29'h0, S_AXI_BVALID, S_AXI_BRESP}, 32'h4);
        @(posedge clk); #1 S_AXI_BREADY = 1'b0;
        check_drained("t1_drained");

        // Simultaneous AW/AR, twice: read wins each time, write follows
        for (int k = 0; k < 2; k++) begin
            a = 32'h0000_0800 + 32'(k * 64);
            fill_wr(1, 0);
            expect_read(a, 2, 3);
            expect_write(a + 32'h400, 1);
            fork
                drive_read(a, 2, 0, 0);
                drive_write(a + 32'h400, 1);
                begin
                    @(negedge clk);
                    check(S_AXI_ARREADY && !S_AXI_AWREADY, "arb_read_first",
                          {30'h0, S_AXI_ARREADY, S_AXI_AWREADY}, 32'h2);
                end
            join
            check_drained("arb_drained");
        end

        // 4-beat read with RREADY toggling
        expect_read(32'h10, 3, 4);
        drive_read(32'h10, 3, 1, 0);
        check(rd_cap[0] == 32'hDEADBEEF, "t2_first_beat", rd_cap[0], 32'hDEADBEEF);
        check_drained("t2_drained");

        // Word-address wrap
        fill_wr(1, 1);
        wrap_d1 = wr_data[1];
        expect_write(32'h3FFC, 1);
        drive_write(32'h3FFC, 1);
        @(negedge clk);
        check(tb_mem[12'hFFF] == wr_data[0], "wrap_fff", tb_mem[12'hFFF], wr_data[0]);
        check(tb_mem[12'h000] == wrap_d1, "wrap_000", tb_mem[12'h000], wrap_d1);
        @(posedge clk); #1;

        // Upper address bits set: SLVERR or alias to word 0
        expect_read(32'h0001_0000, 1, 2);
        drive_read(32'h0001_0000, 1, 0, 0);
        check(rd_cap[0] == (ERR_EN ? 32'h0 : wrap_d1), "alias_or_err", rd_cap[0],
              ERR_EN ? 32'h0 : wrap_d1);
        check_drained("err_drained");

        // Reset mid 8-beat read after beat 3
        expect_read(32'h100, 7, 3);
        drive_read(32'h100, 7, 0, 3);
        rst = 1'b1;
        @(negedge clk);
        check({S_AXI_AWREADY, S_AXI_ARREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_RVALID,
               S_AXI_RLAST, mem_en, mem_we, S_AXI_BRESP, S_AXI_RRESP} == '0, "midreset_outputs",
              {20'h0, S_AXI_AWREADY, S_AXI_ARREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_RVALID,
               S_AXI_RLAST, mem_en, mem_we, S_AXI_BRESP}, 32'h0);
        check_drained("midreset_drained");
        @(posedge clk); #1 rst = 1'b0;
        expect_read(32'h100, 7, 8);
        drive_read(32'h100, 7, 0, 0);
        check_drained("post_reset_drained");

        // Random traffic
        for (int t = 0; t < 30; t++) begin
            a = $urandom & 32'h0000_3FFF;
            if ($urandom_range(0, 7) == 0) a = a | 32'h0004_0000;
            len = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                fill_wr(len, 0);
                expect_write(a, len);
                drive_write(a, len);
            end else begin
                expect_read(a, len, len + 1);
                drive_read(a, len, 0, 0);
            end
        end
        check_drained("random_drained");

        // Maximum burst length
        a = $urandom & 32'h0000_3FFF;
        expect_read(a, 255, 256);
        drive_read(a, 255, 0, 0);
        check_drained("len255_drained");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
